corr_decoder_frame: RTL and testbench
=====================================

Name: corr_decoder_frame

Overview:
- Parametrised successor of the chip-correlation symbol decoder.
- Accepts one N_CHIPS-wide chip word per symbol over a valid/ready handshake and correlates it bit-serially against a runtime-loadable ±1 weight vector.
- Slices the signed correlation into a 2-bit symbol and packs N_SYMS symbols into a frame word.
- Sits between the chip sampler and the frame consumer; replaces the fixed 80-chip/112-symbol, ROM-weighted decoder.

Parameters:
- N_CHIPS, 80: chips per symbol, which is also the width of in_data and of the weight vector; legal range 2..256.
- N_SYMS, 112: symbols per frame; frame width is 2*N_SYMS; legal range 1..128.
- ERASE_THR, 8: erasure magnitude threshold, used only when the optional feature is compiled in; legal range 0..N_CHIPS.
- Derived localparam ACC_W = $clog2(N_CHIPS+1)+1: signed accumulator width, covering the range -N_CHIPS..+N_CHIPS.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- in_data  in  N_CHIPS  chip word; bit i is chip i
- in_valid  in  1  chip word valid
- in_ready  out  1  decoder can accept a chip word
- weight_in  in  N_CHIPS  weight vector; bit value 1 = +1, 0 = -1
- weight_load  in  1  load strobe for weight_in
- frame_flush  in  1  discard the partial frame
- sym_out  out  2  decided symbol
- sym_valid  out  1  one-cycle pulse, sym_out valid
- sym_idx  out  $clog2(N_SYMS) (minimum 1)  frame slot of the current sym_out
- frame_out  out  2*N_SYMS  last completed frame
- frame_valid  out  1  one-cycle pulse, frame_out updated

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE. Accumulator, chip index, symbol counter, partial frame, weights, sym_out, sym_idx, frame_out are all cleared to 0.
  - sym_valid, frame_valid and in_ready are 0 while rst is high.
  - Reset mid-operation aborts the in-flight symbol and the partial frame without any output pulse.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, in_data is latched, acc <= 0, idx <= 0, go to ACCUM.
  - ACCUM: each cycle acc += (sample[idx] XNOR weight[idx]) ? +1 : -1, then idx++. After chip N_CHIPS-1 go to DECIDE. Chips are processed LSB first.
  - DECIDE: symbol = (acc > 0) ? 2'b10 : 2'b01, so acc == 0 gives 01. The symbol is registered to sym_out with sym_valid = 1 and sym_idx = slot, written into frame slot k (bits [2k+1:2k]), and the FSM returns to IDLE.
- Latency and throughput:
  - Handshake at edge E0 → sym_valid high in the cycle after edge E0+N_CHIPS+1.
  - in_ready is high in that same cycle.
  - Throughput is one symbol per N_CHIPS+2 cycles with in_valid held high.
- Frame completion:
  - When slot N_SYMS-1 is written, frame_out <= completed frame and frame_valid pulses in the same cycle as sym_valid.
  - The symbol counter wraps to 0 and the partial frame register clears.
  - frame_out holds stable until the next completed frame.
- Weights:
  - weight_load is honoured only in IDLE; it is ignored in ACCUM and DECIDE.
  - If weight_load and the handshake coincide in IDLE, the new weights apply to that symbol.
- frame_flush:
  - Honoured only in IDLE: clears the symbol counter and the partial frame; frame_out is untouched.
  - If frame_flush coincides with the handshake, the flush applies first and the symbol lands in slot 0.
  - Ignored outside IDLE.
- Arithmetic: acc is two's complement ACC_W bits and cannot overflow by construction.

Optional Feature:
- Macro: CORR_DECODER_ERASURE_EN.
- Defined: DECIDE emits 2'b00 (erasure) when |acc| < ERASE_THR; otherwise 10 for acc > 0 and 01 for acc < 0. Erasures occupy their slot normally.
- Undefined: pure sign slicing as above; ERASE_THR unused; 2'b00 is never output.

Test Plan:
- Weights = 80'hA5..A5, in_data = weights → acc = +80, sym_out = 10, sym_valid exactly 82 cycles after the handshake, sym_idx = 0.
- in_data = ~weights → acc = -80 → sym_out = 01.
- in_data with exactly 40 matching chips → acc = 0 → 01 with the macro undefined; 00 with the macro defined (ERASURE_EN, ERASE_THR = 8). A 45-match word (acc = +10) → 10 in both builds.
- 112 back-to-back symbols alternating 10/01 → a single frame_valid, frame_out = 224'h6666…6 (56 hex digits). The 113th symbol goes to sym_idx = 0 and frame_out holds.
- Assert rst for 1 cycle at the 40th ACCUM cycle → no sym_valid; in_ready = 1 the cycle after release; the next symbol goes to slot 0; weights read back as 0 (all chips -1).
- weight_load pulsed during ACCUM → ignored and the current symbol is unchanged. frame_flush pulsed in IDLE after 5 symbols → the next symbol is at sym_idx = 0 and frame_out is unchanged.

Source files
------------

// File: rtl/corr_decoder_frame.sv
// corr_decoder_frame
//   Chip-correlation symbol decoder with frame packing. Each accepted chip
//   word is correlated bit-serially (LSB first, one chip per cycle) against a
//   runtime-loadable +/-1 weight vector. The signed sum is sliced into a
//   2-bit symbol, which is placed in the next slot of a frame of N_SYMS
//   symbols.
//
//   Optional build macro: CORR_DECODER_ERASURE_EN
//     When defined, a correlation with magnitude below ERASE_THR is reported
//     as an erasure (2'b00) instead of a sign decision.
//
// Parameters
//   N_CHIPS    chips per symbol, width of in_data / weight_in (2..256)
//   N_SYMS     symbols per frame, frame width is 2*N_SYMS (1..128)
//   ERASE_THR  erasure magnitude threshold (0..N_CHIPS), erasure build only
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_data      chip word, bit i is chip i
//   in_valid     chip word valid
//   in_ready     decoder can accept a chip word (IDLE, not in reset)
//   weight_in    weight vector, 1 = +1, 0 = -1
//   weight_load  load strobe for weight_in (honoured in IDLE only)
//   frame_flush  discard the partial frame (honoured in IDLE only)
//   sym_out      decided symbol: 10 = positive, 01 = non-positive, 00 = erasure
//   sym_valid    one-cycle pulse, sym_out / sym_idx valid
//   sym_idx      frame slot of the current sym_out
//   frame_out    last completed frame, slot k in bits [2k+1:2k]
//   frame_valid  one-cycle pulse, frame_out updated

module corr_decoder_frame #(
    parameter int N_CHIPS   = 80,
    parameter int N_SYMS    = 112,
    parameter int ERASE_THR = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_CHIPS-1:0]                           in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [N_CHIPS-1:0]                           weight_in,
    input  logic                                         weight_load,
    input  logic                                         frame_flush,
    output logic [1:0]                                   sym_out,
    output logic                                         sym_valid,
    output logic [((N_SYMS > 1) ? $clog2(N_SYMS) : 1)-1:0] sym_idx,
    output logic [2*N_SYMS-1:0]                          frame_out,
    output logic                                         frame_valid
);

    localparam int ACC_W   = $clog2(N_CHIPS + 1) + 1;
    localparam int IDX_W   = $clog2(N_CHIPS);
    localparam int SIDX_W  = (N_SYMS > 1) ? $clog2(N_SYMS) : 1;
    localparam int FRAME_W = 2 * N_SYMS;

    // Elaboration-time guard on the legal parameter ranges.
    if (N_CHIPS < 2 || N_CHIPS > 256 || N_SYMS < 1 || N_SYMS > 128 ||
        ERASE_THR < 0 || ERASE_THR > N_CHIPS) begin : g_param_check
        $error("corr_decoder_frame: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [N_CHIPS-1:0]        sample;
    logic [N_CHIPS-1:0]        weights;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_step;
    logic [IDX_W-1:0]          idx;
    logic                      idx_last;
    logic [SIDX_W-1:0]         sym_cnt;
    logic                      slot_last;
    logic [FRAME_W-1:0]        frame_part;
    logic [FRAME_W-1:0]        frame_next;
    logic [1:0]                sym_dec;
    logic                      sym_valid_r;
    logic                      frame_valid_r;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    assign idx_last = (idx == IDX_W'(N_CHIPS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (idx_last) begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and pulse outputs are forced low for as long as rst is high,
    // not only after the reset edge.
    assign in_ready    = (state == IDLE) && !rst;
    assign sym_valid   = sym_valid_r && !rst;
    assign frame_valid = frame_valid_r && !rst;

    // ------------------------------------------------------------------
    // Correlation step: matching chip adds +1, mismatching chip adds -1
    // ('1 is -1 in two's complement).
    // ------------------------------------------------------------------
    always_comb begin
        acc_step = '1;
        if (sample[idx] ~^ weights[idx]) begin
            acc_step = ACC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Symbol slicer
    // ------------------------------------------------------------------
`ifdef CORR_DECODER_ERASURE_EN
    logic [ACC_W-1:0] acc_mag;

    always_comb begin
        acc_mag = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
        if (acc_mag < ACC_W'(ERASE_THR)) begin
            sym_dec = 2'b00;
        end else if (acc > 0) begin
            sym_dec = 2'b10;
        end else begin
            sym_dec = 2'b01;
        end
    end
`else
    // acc == 0 deliberately falls into the 01 decision.
    always_comb begin
        sym_dec = 2'b01;
        if (acc > 0) begin
            sym_dec = 2'b10;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Partial frame with the current symbol inserted at slot sym_cnt
    // ------------------------------------------------------------------
    assign slot_last = (sym_cnt == SIDX_W'(N_SYMS - 1));

    always_comb begin
        frame_next = frame_part;
        for (int unsigned k = 0; k < N_SYMS; k++) begin
            if (sym_cnt == SIDX_W'(k)) begin
                frame_next[2*k +: 2] = sym_dec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sample        <= '0;
            weights       <= '0;
            acc           <= '0;
            idx           <= '0;
            sym_cnt       <= '0;
            frame_part    <= '0;
            sym_out       <= '0;
            sym_idx       <= '0;
            frame_out     <= '0;
            sym_valid_r   <= 1'b0;
            frame_valid_r <= 1'b0;
        end else begin
            sym_valid_r   <= 1'b0;
            frame_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    // Flush takes effect before a coincident handshake, so
                    // that symbol lands in slot 0.
                    if (frame_flush) begin
                        sym_cnt    <= '0;
                        frame_part <= '0;
                    end
                    // Weights loaded together with a handshake are already
                    // in place for the first ACCUM cycle of that symbol.
                    if (weight_load) begin
                        weights <= weight_in;
                    end
                    if (in_valid) begin
                        sample <= in_data;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + acc_step;
                    idx <= idx + IDX_W'(1);
                end
                DECIDE: begin
                    sym_out     <= sym_dec;
                    sym_idx     <= sym_cnt;
                    sym_valid_r <= 1'b1;
                    if (slot_last) begin
                        frame_out     <= frame_next;
                        frame_valid_r <= 1'b1;
                        sym_cnt       <= '0;
                        frame_part    <= '0;
                    end else begin
                        frame_part <= frame_next;
                        sym_cnt    <= sym_cnt + SIDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_decoder_frame.sv
// tb_corr_decoder_frame
//   Directed self-checking bench for corr_decoder_frame at its default size
//   (80 chips, 112 symbols per frame). Expected values are hand-derived
//   constants; the erasure expectation follows CORR_DECODER_ERASURE_EN.

module tb_corr_decoder_frame;

  localparam int N  = 80;
  localparam int NS = 112;
  localparam int SW = 7;

  logic              clk;
  logic              rst;
  logic [N-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      weight_in;
  logic              weight_load;
  logic              frame_flush;
  logic [1:0]        sym_out;
  logic              sym_valid;
  logic [SW-1:0]     sym_idx;
  logic [2*NS-1:0]   frame_out;
  logic              frame_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0]    w_pat;
  logic [N-1:0]    m40;
  logic [N-1:0]    m35;
  logic [2*NS-1:0] f6;
  logic [1:0]      exp_zero;

  int          got_lat;
  logic [1:0]  got_sym;
  int          got_idx;
  logic        got_fv;
  logic        got_rdy_hs;
  logic        got_rdy_sv;

  corr_decoder_frame dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .weight_in   (weight_in),
    .weight_load (weight_load),
    .frame_flush (frame_flush),
    .sym_out     (sym_out),
    .sym_valid   (sym_valid),
    .sym_idx     (sym_idx),
    .frame_out   (frame_out),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One symbol: handshake, then wait (bounded) for sym_valid. got_lat is the
  // number of cycles after the handshake edge in which sym_valid is seen,
  // or -1 on timeout. Optionally pulses weight_load mid-ACCUM.
  task automatic run_sym(input logic [N-1:0] d, input bit wload_mid);
    int cyc;
    @(negedge clk);
    got_rdy_hs = in_ready;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    got_lat = -1;
    got_sym = 2'bxx;
    got_idx = -1;
    got_fv  = 1'bx;
    got_rdy_sv = 1'bx;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (wload_mid && cyc == 10) begin
        weight_in   = ~w_pat;
        weight_load = 1'b1;
      end
      if (wload_mid && cyc == 11) begin
        weight_load = 1'b0;
      end
      if (sym_valid === 1'b1) begin
        got_lat    = cyc;
        got_sym    = sym_out;
        got_idx    = int'(sym_idx);
        got_fv     = frame_valid;
        got_rdy_sv = in_ready;
        break;
      end
    end
    n_checks++;
    if (got_lat < 0) begin
      n_errors++;
      $error("FAIL run_sym_timeout: no sym_valid within %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc;
    int sv_seen;

    w_pat    = {10{8'hA5}};
    m40      = {40'h0, 40'hFF_FFFF_FFFF};
    m35      = {45'h0, 35'h7_FFFF_FFFF};
    f6       = {56{4'h6}};
`ifdef CORR_DECODER_ERASURE_EN
    exp_zero = 2'b00;
`else
    exp_zero = 2'b01;
`endif

    rst         = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    weight_in   = '0;
    weight_load = 1'b0;
    frame_flush = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_low", in_ready, 1'b0);
    check("rst_sym_valid_low", sym_valid, 1'b0);
    check("rst_frame_valid_low", frame_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready_after", in_ready, 1'b1);
    check("rst_sym_out", sym_out, 2'b00);
    check("rst_sym_idx", sym_idx, 0);
    check("rst_frame_out", frame_out, '0);

    // ---------------- load weights in IDLE ----------------
    @(negedge clk);
    weight_in   = w_pat;
    weight_load = 1'b1;
    @(posedge clk);
    #1;
    weight_load = 1'b0;

    // ---------------- full match: +80 ----------------
    run_sym(w_pat, 1'b0);
    check("match_ready_hs", got_rdy_hs, 1'b1);
    check("match_latency", got_lat, 82);
    check("match_sym", got_sym, 2'b10);
    check("match_idx", got_idx, 0);
    check("match_ready_at_sv", got_rdy_sv, 1'b1);
    check("match_fv", got_fv, 1'b0);
    @(negedge clk);
    check("sym_valid_one_cycle", sym_valid, 1'b0);

    // ---------------- full mismatch: -80 ----------------
    run_sym(~w_pat, 1'b0);
    check("mismatch_sym", got_sym, 2'b01);
    check("mismatch_idx", got_idx, 1);

    // ---------------- 40 matches: acc 0 ----------------
    run_sym(w_pat ^ m40, 1'b0);
    check("zero_sym", got_sym, exp_zero);
    check("zero_idx", got_idx, 2);

    // ---------------- 45 matches: acc +10 ----------------
    run_sym(w_pat ^ m35, 1'b0);
    check("plus10_sym", got_sym, 2'b10);
    check("plus10_idx", got_idx, 3);

    // ---------------- weight_load during ACCUM is ignored ----------------
    run_sym(w_pat, 1'b1);
    check("wload_accum_sym", got_sym, 2'b10);
    check("wload_accum_idx", got_idx, 4);

    // ---------------- flush in IDLE after 5 symbols ----------------
    @(negedge clk);
    frame_flush = 1'b1;
    @(posedge clk);
    #1;
    frame_flush = 1'b0;
    run_sym(w_pat, 1'b0);
    check("flush_weights_kept_sym", got_sym, 2'b10);
    check("flush_idx", got_idx, 0);
    check("flush_frame_out", frame_out, '0);

    // ---------------- back-to-back frame, flush with handshake ----------------
    @(negedge clk);
    in_data     = w_pat;
    in_valid    = 1'b1;
    frame_flush = 1'b1;
    @(posedge clk);
    #1;
    frame_flush = 1'b0;
    for (int unsigned k = 0; k < NS + 1; k++) begin
      cyc = 0;
      sv_seen = 0;
      while (cyc < 300 && sv_seen == 0) begin
        @(negedge clk);
        cyc++;
        if (sym_valid === 1'b1) sv_seen = 1;
      end
      check("stream_period", cyc, 82);
      check("stream_sym", sym_out, ((k % 2) == 0) ? 2'b10 : 2'b01);
      check("stream_idx", sym_idx, k % NS);
      check("stream_fv", frame_valid, (k == NS - 1) ? 1'b1 : 1'b0);
      if (k == 0) begin
        check("stream_frame_before", frame_out, '0);
      end
      if (k >= NS - 1) begin
        check("stream_frame_out", frame_out, f6);
      end
      if (k == NS) begin
        in_valid = 1'b0;
      end else begin
        in_data = (((k + 1) % 2) == 0) ? w_pat : ~w_pat;
      end
    end

    // ---------------- flush after a completed frame keeps frame_out ----------------
    @(negedge clk);
    frame_flush = 1'b1;
    @(posedge clk);
    #1;
    frame_flush = 1'b0;
    run_sym(~w_pat, 1'b0);
    check("flush2_sym", got_sym, 2'b01);
    check("flush2_idx", got_idx, 0);
    check("flush2_frame_hold", frame_out, f6);

    // ---------------- reset at the 40th ACCUM cycle ----------------
    @(negedge clk);
    in_data  = w_pat;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_low", in_ready, 1'b0);
    check("midrst_sym_valid_low", sym_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready_after", in_ready, 1'b1);
    check("midrst_frame_out", frame_out, '0);
    check("midrst_sym_idx", sym_idx, 0);
    sv_seen = 0;
    for (int unsigned c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sym_valid === 1'b1) sv_seen++;
    end
    check("midrst_no_sym_valid", sv_seen, 0);
    // Cleared weights are all -1, so an all-zero word matches every chip.
    run_sym({N{1'b0}}, 1'b0);
    check("midrst_weights_cleared_sym", got_sym, 2'b10);
    check("midrst_next_idx", got_idx, 0);
    check("midrst_latency", got_lat, 82);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
